dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RISC-V core: the slave end of the M-stage load/store interface (address, store data, write strobe, RISC-V funct3 access size). It serves combinational loads with byte/half/word lane extraction and sign/zero extension, commits stores on the clock edge with byte-lane masking, and zero-fills its array after every reset through a clear sequencer. It sits between the core's M stage and the top level, which holds the core in reset until `ready` rises.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: array depth in 32-bit words; power of two, minimum 4.
- `ADDR_BASE`, 32'h0: byte address of word 0; must be 4-byte aligned.

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address (core `aluoutM`).
- `wdata`  in  32  store data, right-aligned (core `writedataM`).
- `we`  in  1  store strobe (core `memwriteM`).
- `re`  in  1  load qualifier (core `memtoregM`); used only for error flagging.
- `memsize`  in  3  funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU; 3, 6, 7 illegal.
- `rdata`  out  32  load data, extended (core `readdataM`).
- `ready`  out  1  high once the clear sequence has finished.
- `store_count`  out  32  number of committed stores.
- `misalign`  out  1  sticky misaligned-access flag.

## Operation
- Index: `idx = ((addr - ADDR_BASE) >> 2) mod DEPTH_WORDS`. Out-of-range addresses wrap; there is no bus error.
- Two-state FSM:
  - CLEAR: counter `clr_idx` writes 0 into `mem[clr_idx]` each cycle. `we` is ignored and `rdata` = 0. After writing `DEPTH_WORDS-1`, the FSM moves to READY.
  - READY: normal service. The FSM never leaves READY except through reset.
- Load, combinational in READY:
  - Fetch word `w = mem[idx]`.
  - Byte: lane `addr[1:0]`; sign-extend for LB, zero-extend for LBU.
  - Half: lane `addr[1]`, low half when 0; sign-extend for LH, zero-extend for LHU.
  - Word: `w`.
  - Illegal `memsize` gives `rdata` = 0.
- Store, on posedge when READY and `we`:
  - SB writes `wdata[7:0]` into lane `addr[1:0]`.
  - SH writes `wdata[15:0]` into lane `addr[1]`.
  - SW writes the full word.
  - Other lanes are preserved. Illegal `memsize`, or `memsize[2]` set, gives no write.
- `store_count` increments by 1 per committed store and wraps modulo 2^32. It does not count suppressed stores.
- Read-during-write to the same word: `rdata` shows the old contents in that cycle and the new contents from the next cycle.

## Timing
- Reset values on `reset_n` low, immediately and asynchronously:
  - FSM = CLEAR, `clr_idx` = 0.
  - `ready` = 0, `store_count` = 0, `misalign` = 0, `rdata` = 0.
- After `reset_n` deasserts, CLEAR occupies exactly `DEPTH_WORDS` posedges. `ready` is registered and rises on posedge number `DEPTH_WORDS`.
- Reset asserted mid-CLEAR or mid-READY restarts the full clear. Array contents are undefined until the clear completes.
- Load latency: 0 cycles, addr to rdata combinational. Store latency: 1 cycle, visible to a load at the same address in the next cycle.
- No handshake stalls. After `ready`, every cycle accepts one access.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, counts as misaligned when qualified by `we` or `re`.
  - A misaligned store is suppressed and not counted.
  - A misaligned load returns 0.
  - `misalign` is set on the posedge and stays set until reset.
- Not defined:
  - Half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.
  - All accesses are serviced.
  - `misalign` is tied to 0.

## Test plan
- Reset with `DEPTH_WORDS`=16:
  - Release `reset_n` → `ready`=0 for 16 posedges, then 1.
  - LW at any address → 0.
  - Assert `reset_n` low at cycle 8 and release → a full 16 cycles again.
- SW 0x80FF_7F01 @0x10:
  - LB 0x10 → 0x0000_0001.
  - LB 0x13 → 0xFFFF_FF80.
  - LBU 0x13 → 0x0000_0080.
  - LH 0x12 → 0xFFFF_80FF.
  - LHU 0x10 → 0x0000_7F01.
- Masking: SW 0xAABBCCDD @0x20, SB 0x11 @0x21, SH 0x2233 @0x22 → LW 0x20 → 0x2233_11DD; `store_count` = 3.
- Same-cycle: SW 0x5 @0x8 while reading 0x8 → `rdata` = old 0 that cycle, 0x5 the next cycle. Address `ADDR_BASE`+4·16 aliases word 0.
- Illegal size: `memsize`=3 with `we` → no write, `rdata`=0, `store_count` unchanged.
- Misalignment, SW @0x2:
  - With `DMEM_MISALIGN_TRAP_EN`: no write, `misalign`=1 until reset.
  - Without it: writes word 0, `misalign`=0.

Source files
------------

// File: rtl/dmem_if.sv
// M-stage load/store bus between the core (master) and the data-memory responder (slave).
interface dmem_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [2:0]  memsize;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, output re, output memsize,
                  input  rdata);
  modport slave  (input  addr, input  wdata, input  we, input  re, input  memsize,
                  output rdata);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: combinational extended loads, byte-masked stores, zero-fill after reset.
// Optional misaligned-access trapping is enabled with DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  dmem_if.slave       bus,
  output logic        ready,
  output logic [31:0] store_count,
  output logic        misalign
);
  // state    | meaning
  // ST_CLEAR | zero-filling the array one word per cycle, accesses ignored
  // ST_READY | normal load/store service until next reset
  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_idx;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [31:0]     r_store_count;

  logic [31:0]     w_off;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic            w_is_half;
  logic            w_is_word;
  logic            w_mis;
  logic            w_store;
  logic [3:0]      w_be;
  logic [31:0]     w_wdat;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_off = bus.addr - ADDR_BASE;
  assign w_idx = w_off[AW+1:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_CLEAR;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_idx == AW'(DEPTH_WORDS - 1)) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_clr_idx <= '0;
    else if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
  end

  assign ready     = (r_state == ST_READY);
  assign w_is_half = (bus.memsize == 3'd1) || (bus.memsize == 3'd5);
  assign w_is_word = (bus.memsize == 3'd2);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_mis = ((w_is_half && bus.addr[0]) || (w_is_word && (bus.addr[1:0] != 2'b00)))
                 && (bus.we || bus.re);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   r_misalign <= 1'b0;
    else if (ready && w_mis)        r_misalign <= 1'b1;
  end
  assign misalign = r_misalign;
  assign w_unused = ^{w_off[31:AW+2], w_off[1:0]};
`else
  assign w_mis    = 1'b0;
  assign misalign = 1'b0;
  assign w_unused = ^{w_off[31:AW+2], w_off[1:0], bus.re, w_is_half, w_is_word};
`endif

  // Unsigned sizes (memsize[2]) are load-only encodings, so they never store.
  assign w_store = ready && bus.we && !bus.memsize[2] && (bus.memsize[1:0] != 2'b11) && !w_mis;

  always_comb begin
    w_be   = 4'b0000;
    w_wdat = bus.wdata;
    case (bus.memsize[1:0])
      2'd0: begin
        w_be   = 4'b0001 << bus.addr[1:0];
        w_wdat = {4{bus.wdata[7:0]}};
      end
      2'd1: begin
        w_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{bus.wdata[15:0]}};
      end
      2'd2:    w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdat[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_store_count <= '0;
    else if (w_store) r_store_count <= r_store_count + 32'd1;
  end
  assign store_count = r_store_count;

  assign w_word = r_mem[w_idx];
  assign w_half = bus.addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (bus.addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if (ready && !w_mis) begin
      case (bus.memsize)
        3'd0:    w_rdata = {{24{w_byte[7]}}, w_byte};
        3'd4:    w_rdata = {24'd0, w_byte};
        3'd1:    w_rdata = {{16{w_half[15]}}, w_half};
        3'd5:    w_rdata = {16'd0, w_half};
        3'd2:    w_rdata = w_word;
        default: w_rdata = '0;
      endcase
    end
  end
  assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed check of dmem_responder against a byte-array reference model.
module tb_dmem_responder;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk;
  logic        reset_n;
  logic        ready;
  logic [31:0] store_count;
  logic        misalign;

  dmem_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .ready(ready), .store_count(store_count), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_b [DEPTH*4];
  logic [31:0] m_cnt;
  logic        m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int m_base(input logic [31:0] a);
    return int'((((a - BASE) >> 2) % DEPTH) * 4);
  endfunction

  function automatic bit m_misaligned(input logic [31:0] a, input logic [2:0] sz,
                                      input logic we, input logic re);
`ifdef DMEM_MISALIGN_TRAP_EN
    bit half = (sz == 3'd1) || (sz == 3'd5);
    return (we || re) && ((half && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] sz,
                                         input logic we, input logic re);
    int base = m_base(a);
    int lo;
    logic [31:0] v;
    if (m_misaligned(a, sz, we, re)) return 32'h0;
    case (sz)
      3'd0, 3'd4: begin
        v = {24'd0, m_b[base + int'(a[1:0])]};
        if (sz == 3'd0 && v[7]) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        lo = base + (a[1] ? 2 : 0);
        v = {16'd0, m_b[lo+1], m_b[lo]};
        if (sz == 3'd1 && v[15]) v = v - 32'd65536;
      end
      3'd2: v = {m_b[base+3], m_b[base+2], m_b[base+1], m_b[base]};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    int base = m_base(a);
    case (sz)
      3'd0: m_b[base + int'(a[1:0])] = d[7:0];
      3'd1: begin
        m_b[base + (a[1] ? 2 : 0)]     = d[7:0];
        m_b[base + (a[1] ? 2 : 0) + 1] = d[15:8];
      end
      3'd2: for (int i = 0; i < 4; i++) m_b[base+i] = d[8*i +: 8];
      default: return;
    endcase
    m_cnt = m_cnt + 32'd1;
  endtask

  // Drive one access for a full cycle; rdata is checked mid-cycle, state after the edge.
  task automatic access(input logic we, input logic re, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp;
    bit mis;
    bus.we = we; bus.re = re; bus.memsize = sz; bus.addr = a; bus.wdata = d;
    exp = m_load(a, sz, we, re);
    mis = m_misaligned(a, sz, we, re);
    #2;
    rd = bus.rdata;
    if (re) check("rdata", rd, exp);
    @(posedge clk);
    if (we && !mis) m_store(a, d, sz);
    if (mis) m_mis = 1'b1;
    #1;
    bus.we = 1'b0; bus.re = 1'b0;
    check("store_count", store_count, m_cnt);
    check("misalign", {31'd0, misalign}, {31'd0, m_mis});
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH*4; i++) m_b[i] = 8'h00;
    m_cnt = 32'd0;
    m_mis = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] cnt0;
    reset_n = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.we = 1'b0; bus.re = 1'b0; bus.memsize = 3'd2;
    model_reset();
    #2;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_count", store_count, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);

    @(negedge clk); reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check("clear1_ready", {31'd0, ready}, 32'd0);
    end
    reset_n = 1'b0;
    #1;
    check("midclear_rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      bus.we = 1'b1; bus.memsize = 3'd2; bus.addr = 32'h4; bus.wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      check("clear2_ready", {31'd0, ready}, (k == DEPTH) ? 32'd1 : 32'd0);
      if (k < DEPTH) check("clear2_rdata", bus.rdata, 32'd0);
    end
    bus.we = 1'b0;
    check("post_clear_count", store_count, 32'd0);

    for (int i = 0; i < 4; i++) begin
      access(1'b0, 1'b1, 3'd2, 32'h0 + 32'(i*20), 32'h0, rd);
      check("lw_zero", rd, 32'd0);
    end

    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h80FF_7F01, rd);
    access(1'b0, 1'b1, 3'd0, 32'h10, 32'h0, rd); check("lb_10",  rd, 32'h0000_0001);
    access(1'b0, 1'b1, 3'd0, 32'h13, 32'h0, rd); check("lb_13",  rd, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 3'd4, 32'h13, 32'h0, rd); check("lbu_13", rd, 32'h0000_0080);
    access(1'b0, 1'b1, 3'd1, 32'h12, 32'h0, rd); check("lh_12",  rd, 32'hFFFF_80FF);
    access(1'b0, 1'b1, 3'd5, 32'h10, 32'h0, rd); check("lhu_10", rd, 32'h0000_7F01);

    cnt0 = store_count;
    access(1'b1, 1'b0, 3'd2, 32'h20, 32'hAABB_CCDD, rd);
    access(1'b1, 1'b0, 3'd0, 32'h21, 32'h0000_0011, rd);
    access(1'b1, 1'b0, 3'd1, 32'h22, 32'h0000_2233, rd);
    access(1'b0, 1'b1, 3'd2, 32'h20, 32'h0, rd); check("mask_lw", rd, 32'h2233_11DD);
    check("mask_count", store_count - cnt0, 32'd3);

    access(1'b1, 1'b1, 3'd2, 32'h8, 32'h5, rd); check("rdw_old", rd, 32'h0);
    access(1'b0, 1'b1, 3'd2, 32'h8, 32'h0, rd); check("rdw_new", rd, 32'h5);
    access(1'b1, 1'b0, 3'd2, BASE + 32'h40, 32'h1234_5678, rd);
    access(1'b0, 1'b1, 3'd2, BASE, 32'h0, rd); check("alias_w0", rd, 32'h1234_5678);

    cnt0 = store_count;
    access(1'b1, 1'b1, 3'd3, 32'h10, 32'hFFFF_FFFF, rd); check("illegal_rdata", rd, 32'h0);
    check("illegal_count", store_count, cnt0);
    access(1'b0, 1'b1, 3'd2, 32'h10, 32'h0, rd); check("illegal_nowrite", rd, 32'h80FF_7F01);

    access(1'b1, 1'b0, 3'd2, 32'h2, 32'hCAFE_F00D, rd);
    access(1'b0, 1'b1, 3'd2, 32'h0, 32'h0, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_nowrite", rd, 32'h1234_5678);
    check("mis_flag", {31'd0, misalign}, 32'd1);
`else
    check("mis_write", rd, 32'hCAFE_F00D);
    check("mis_flag", {31'd0, misalign}, 32'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      access(1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom, rd);
    end

    reset_n = 1'b0;
    #1;
    check("final_rst_count", store_count, 32'd0);
    check("final_rst_ready", {31'd0, ready}, 32'd0);
    check("final_rst_misalign", {31'd0, misalign}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
